pong_collision_engine: RTL and testbench
========================================

Name: pong_collision_engine

Overview:
Per-frame ball physics and collision engine for the pong display path, generalised to NUM_PADDLES paddles. On each new-frame pulse it advances the ball, scans paddle boxes sequentially, reflects off walls and paddles, keeps score and runs serve/game-over sequencing. Its ball position feeds the existing box-draw logic; paddle boxes come from the moving-paddle blocks.

Parameters:
NUM_PADDLES, 2, number of paddle boxes scanned (1..8)
COORD_W, 13, coordinate width in bits
BALL_SIZE, 10, ball edge length in pixels (square)
SCREEN_W, 640, playfield width; valid x is 0..SCREEN_W-1
SCREEN_H, 480, playfield height; valid y is 0..SCREEN_H-1
SPEED_X, 4, horizontal step per frame in pixels
SPEED_Y, 3, vertical step per frame in pixels
SERVE_FRAMES, 60, frames the ball is held at centre before launch
SCORE_W, 4, score counter width
MAX_SCORE, 9, score that ends the game

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
new_frame  in  1  one-cycle pulse per video frame
pause  in  1  freezes all motion and serve counting while high
pad_left  in  NUM_PADDLES*COORD_W  paddle left edges, paddle i at bits [i*COORD_W +: COORD_W]
pad_right  in  NUM_PADDLES*COORD_W  paddle right edges (inclusive)
pad_top  in  NUM_PADDLES*COORD_W  paddle top edges
pad_bottom  in  NUM_PADDLES*COORD_W  paddle bottom edges (inclusive)
ball_x  out  COORD_W  ball top-left column
ball_y  out  COORD_W  ball top-left row
hit_valid  out  1  one-cycle pulse, paddle collision this frame
hit_idx  out  3  index of paddle hit (valid with hit_valid)
score_l  out  SCORE_W  left player score
score_r  out  SCORE_W  right player score
game_over  out  1  high once either score reaches MAX_SCORE
busy  out  1  high while a frame update is in progress

Behaviour:
- Reset (synchronous, active-high): ball_x=(SCREEN_W-BALL_SIZE)/2 (315), ball_y=(SCREEN_H-BALL_SIZE)/2 (235), dir_x=+, dir_y=+, scores 0, hit_valid 0, game_over 0, busy 0, serve counter 0, state SERVE.
- States: SERVE, IDLE, STEP, SCAN, COMMIT, OVER.
- SERVE: ball held at centre; each new_frame with pause=0 increments counter; at SERVE_FRAMES -> IDLE, counter cleared.
- IDLE: new_frame with pause=0 -> STEP, busy=1. new_frame with pause=1 ignored.
- STEP (1 cycle): nx=ball_x±SPEED_X, ny=ball_y±SPEED_Y computed in COORD_W+1 signed to detect underflow.
- SCAN: one paddle per cycle, index 0..NUM_PADDLES-1. Hit if boxes overlap inclusively: nx<=right, nx+BALL_SIZE-1>=left, ny<=bottom, ny+BALL_SIZE-1>=top. First (lowest-index) hit latched; later hits ignored.
- COMMIT (1 cycle), priority order:
  1. Paddle hit: dir_x flips; nx=left-BALL_SIZE if moving right, right+1 if moving left; hit_valid pulses with hit_idx.
  2. Else nx<0: score_r+1, centre ball, dir_x=+, -> SERVE.
  3. Else nx+BALL_SIZE>SCREEN_W: score_l+1, centre ball, dir_x=-, -> SERVE.
- Vertical wall handling applies in every case: ny<0 -> ny=0, dir_y flips; ny+BALL_SIZE>SCREEN_H -> ny=SCREEN_H-BALL_SIZE, dir_y flips.
- Outputs update on COMMIT; busy drops. Latency from new_frame to new ball_x/ball_y: NUM_PADDLES+2 cycles.
- If a score reaches MAX_SCORE in COMMIT: -> OVER, game_over=1. OVER holds all outputs until reset.
- new_frame arriving while busy=1 is dropped; there is no queueing.
- pause rising during STEP/SCAN/COMMIT does not abort the update in progress.
- Scores saturate at MAX_SCORE.

Decomposition:
- Shared package pong_pkg holds the state enum, COORD_W, and the default screen and ball constants.
- One natural sub-module: box_overlap, a combinational inclusive AABB test reused in SCAN.

Test Plan:
- Reset, then 60 new_frame pulses -> stays at (315,235); pulse 61 plus 4 cycles -> (319,238).
- Ball at y=2 moving up -> y=0, dir_y=+; next frame y=3.
- Paddle 1 box (600..619, 200..259), ball at (588,220) moving right -> hit_valid with hit_idx=1, ball_x=590, dir_x=-.
- Paddles 0 and 1 both overlap the ball -> hit_idx=0.
- Ball at x=2 moving left, no paddle -> score_r=1, ball at (315,235), state SERVE, dir_x=+.
- score_l=8 and left player scores -> score_l=9, game_over=1; further new_frame pulses leave outputs frozen; reset clears everything.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and default constants for the pong ball/collision engine.
package pong_pkg;

    localparam int DEF_COORD_W   = 13;
    localparam int DEF_SCREEN_W  = 640;
    localparam int DEF_SCREEN_H  = 480;
    localparam int DEF_BALL_SIZE = 10;

    typedef enum logic [2:0] {
        ST_SERVE,
        ST_IDLE,
        ST_STEP,
        ST_SCAN,
        ST_COMMIT,
        ST_OVER
    } state_t;

endpackage

// File: rtl/box_overlap.sv
// Inclusive axis-aligned overlap test between a square ball and one paddle box.
module box_overlap #(
    parameter int W    = 15,
    parameter int SIZE = 10
) (
    input  logic signed [W-1:0] bx,
    input  logic signed [W-1:0] by,
    input  logic signed [W-1:0] left,
    input  logic signed [W-1:0] right,
    input  logic signed [W-1:0] top,
    input  logic signed [W-1:0] bottom,
    output logic                hit
);

    logic signed [W-1:0] bx_far;
    logic signed [W-1:0] by_far;

    always_comb begin
        bx_far = bx + W'(SIZE - 1);
        by_far = by + W'(SIZE - 1);
        hit    = (bx <= right) && (bx_far >= left) && (by <= bottom) && (by_far >= top);
    end

endmodule

// File: rtl/pong_collision_engine.sv
// Per-frame ball advance, sequential paddle scan, wall/paddle reflection,
// scoring and serve/game-over sequencing.
module pong_collision_engine
    import pong_pkg::*;
#(
    parameter int NUM_PADDLES  = 2,
    parameter int COORD_W      = DEF_COORD_W,
    parameter int BALL_SIZE    = DEF_BALL_SIZE,
    parameter int SCREEN_W     = DEF_SCREEN_W,
    parameter int SCREEN_H     = DEF_SCREEN_H,
    parameter int SPEED_X      = 4,
    parameter int SPEED_Y      = 3,
    parameter int SERVE_FRAMES = 60,
    parameter int SCORE_W      = 4,
    parameter int MAX_SCORE    = 9
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           new_frame,
    input  logic                           pause,
    input  logic [NUM_PADDLES*COORD_W-1:0] pad_left,
    input  logic [NUM_PADDLES*COORD_W-1:0] pad_right,
    input  logic [NUM_PADDLES*COORD_W-1:0] pad_top,
    input  logic [NUM_PADDLES*COORD_W-1:0] pad_bottom,
    output logic [COORD_W-1:0]             ball_x,
    output logic [COORD_W-1:0]             ball_y,
    output logic                           hit_valid,
    output logic [2:0]                     hit_idx,
    output logic [SCORE_W-1:0]             score_l,
    output logic [SCORE_W-1:0]             score_r,
    output logic                           game_over,
    output logic                           busy
);

    localparam int NW    = COORD_W + 1;
    localparam int SW    = COORD_W + 2;
    localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

    localparam logic [COORD_W-1:0]    CENTRE_X = COORD_W'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [COORD_W-1:0]    CENTRE_Y = COORD_W'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic signed [NW-1:0]  STEP_X   = NW'(SPEED_X);
    localparam logic signed [NW-1:0]  STEP_Y   = NW'(SPEED_Y);
    localparam logic signed [NW-1:0]  X_MAX    = NW'(SCREEN_W - BALL_SIZE);
    localparam logic signed [NW-1:0]  Y_MAX    = NW'(SCREEN_H - BALL_SIZE);
    localparam logic [SCORE_W-1:0]    SCORE_MX = SCORE_W'(MAX_SCORE);

    state_t                    state_q, state_d;
    logic [COORD_W-1:0]        ball_x_q, ball_x_d, ball_y_q, ball_y_d;
    logic                      dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic signed [NW-1:0]      nx_q, nx_d, ny_q, ny_d;
    logic [2:0]                scan_idx_q, scan_idx_d;
    logic                      hit_q, hit_d;
    logic [2:0]                hit_sel_q, hit_sel_d;
    logic [COORD_W-1:0]        hit_left_q, hit_left_d, hit_right_q, hit_right_d;
    logic                      hit_valid_q, hit_valid_d;
    logic [2:0]                hit_idx_q, hit_idx_d;
    logic [SCORE_W-1:0]        score_l_q, score_l_d, score_r_q, score_r_d;
    logic                      game_over_q, game_over_d;
    logic                      busy_q, busy_d;
    logic [CNT_W-1:0]          serve_cnt_q, serve_cnt_d;

    // Unused slots are tied off so the 3-bit scan index always addresses a full array.
    logic [COORD_W-1:0] pl [8];
    logic [COORD_W-1:0] pr [8];
    logic [COORD_W-1:0] pt [8];
    logic [COORD_W-1:0] pb [8];

    for (genvar g = 0; g < 8; g++) begin : g_pad
        if (g < NUM_PADDLES) begin : g_used
            assign pl[g] = pad_left  [g*COORD_W +: COORD_W];
            assign pr[g] = pad_right [g*COORD_W +: COORD_W];
            assign pt[g] = pad_top   [g*COORD_W +: COORD_W];
            assign pb[g] = pad_bottom[g*COORD_W +: COORD_W];
        end else begin : g_unused
            assign pl[g] = '0;
            assign pr[g] = '0;
            assign pt[g] = '0;
            assign pb[g] = '0;
        end
    end

    logic signed [SW-1:0] s_bx, s_by, s_l, s_r, s_t, s_b;
    logic                 ov_hit;

    always_comb begin
        s_bx = {nx_q[NW-1], nx_q};
        s_by = {ny_q[NW-1], ny_q};
        s_l  = {2'b00, pl[scan_idx_q]};
        s_r  = {2'b00, pr[scan_idx_q]};
        s_t  = {2'b00, pt[scan_idx_q]};
        s_b  = {2'b00, pb[scan_idx_q]};
    end

    box_overlap #(.W(SW), .SIZE(BALL_SIZE)) u_overlap (
        .bx     (s_bx),
        .by     (s_by),
        .left   (s_l),
        .right  (s_r),
        .top    (s_t),
        .bottom (s_b),
        .hit    (ov_hit)
    );

    always_comb begin
        state_d     = state_q;
        ball_x_d    = ball_x_q;
        ball_y_d    = ball_y_q;
        dir_x_d     = dir_x_q;
        dir_y_d     = dir_y_q;
        nx_d        = nx_q;
        ny_d        = ny_q;
        scan_idx_d  = scan_idx_q;
        hit_d       = hit_q;
        hit_sel_d   = hit_sel_q;
        hit_left_d  = hit_left_q;
        hit_right_d = hit_right_q;
        hit_valid_d = 1'b0;
        hit_idx_d   = hit_idx_q;
        score_l_d   = score_l_q;
        score_r_d   = score_r_q;
        game_over_d = game_over_q;
        busy_d      = busy_q;
        serve_cnt_d = serve_cnt_q;

        case (state_q)
            ST_SERVE: begin
                if (new_frame && !pause) begin
                    if (serve_cnt_q == CNT_W'(SERVE_FRAMES - 1)) begin
                        serve_cnt_d = '0;
                        state_d     = ST_IDLE;
                    end else begin
                        serve_cnt_d = serve_cnt_q + 1'b1;
                    end
                end
            end
            ST_IDLE: begin
                if (new_frame && !pause) begin
                    busy_d  = 1'b1;
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                nx_d       = dir_x_q ? ({1'b0, ball_x_q} + STEP_X) : ({1'b0, ball_x_q} - STEP_X);
                ny_d       = dir_y_q ? ({1'b0, ball_y_q} + STEP_Y) : ({1'b0, ball_y_q} - STEP_Y);
                scan_idx_d = '0;
                hit_d      = 1'b0;
                state_d    = ST_SCAN;
            end
            ST_SCAN: begin
                if (ov_hit && !hit_q) begin
                    hit_d       = 1'b1;
                    hit_sel_d   = scan_idx_q;
                    hit_left_d  = pl[scan_idx_q];
                    hit_right_d = pr[scan_idx_q];
                end
                if (scan_idx_q == 3'(NUM_PADDLES - 1)) begin
                    state_d = ST_COMMIT;
                end else begin
                    scan_idx_d = scan_idx_q + 1'b1;
                end
            end
            ST_COMMIT: begin
                busy_d   = 1'b0;
                state_d  = ST_IDLE;
                ball_y_d = ny_q[COORD_W-1:0];
                if (ny_q[NW-1]) begin
                    ball_y_d = '0;
                    dir_y_d  = ~dir_y_q;
                end else if (ny_q > Y_MAX) begin
                    ball_y_d = Y_MAX[COORD_W-1:0];
                    dir_y_d  = ~dir_y_q;
                end

                // Scoring overrides the clamped y with the serve position; dir_y keeps its flip.
                if (hit_q) begin
                    dir_x_d     = ~dir_x_q;
                    ball_x_d    = dir_x_q ? (hit_left_q - COORD_W'(BALL_SIZE))
                                          : (hit_right_q + COORD_W'(1));
                    hit_valid_d = 1'b1;
                    hit_idx_d   = hit_sel_q;
                end else if (nx_q[NW-1]) begin
                    score_r_d = (score_r_q == SCORE_MX) ? score_r_q : score_r_q + 1'b1;
                    ball_x_d  = CENTRE_X;
                    ball_y_d  = CENTRE_Y;
                    dir_x_d   = 1'b1;
                    state_d   = ST_SERVE;
                end else if (nx_q > X_MAX) begin
                    score_l_d = (score_l_q == SCORE_MX) ? score_l_q : score_l_q + 1'b1;
                    ball_x_d  = CENTRE_X;
                    ball_y_d  = CENTRE_Y;
                    dir_x_d   = 1'b0;
                    state_d   = ST_SERVE;
                end else begin
                    ball_x_d = nx_q[COORD_W-1:0];
                end

                if ((score_l_d == SCORE_MX) || (score_r_d == SCORE_MX)) begin
                    game_over_d = 1'b1;
                    state_d     = ST_OVER;
                end
            end
            ST_OVER: begin
            end
            default: state_d = ST_SERVE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_SERVE;
            ball_x_q    <= CENTRE_X;
            ball_y_q    <= CENTRE_Y;
            dir_x_q     <= 1'b1;
            dir_y_q     <= 1'b1;
            nx_q        <= '0;
            ny_q        <= '0;
            scan_idx_q  <= '0;
            hit_q       <= 1'b0;
            hit_sel_q   <= '0;
            hit_left_q  <= '0;
            hit_right_q <= '0;
            hit_valid_q <= 1'b0;
            hit_idx_q   <= '0;
            score_l_q   <= '0;
            score_r_q   <= '0;
            game_over_q <= 1'b0;
            busy_q      <= 1'b0;
            serve_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ball_x_q    <= ball_x_d;
            ball_y_q    <= ball_y_d;
            dir_x_q     <= dir_x_d;
            dir_y_q     <= dir_y_d;
            nx_q        <= nx_d;
            ny_q        <= ny_d;
            scan_idx_q  <= scan_idx_d;
            hit_q       <= hit_d;
            hit_sel_q   <= hit_sel_d;
            hit_left_q  <= hit_left_d;
            hit_right_q <= hit_right_d;
            hit_valid_q <= hit_valid_d;
            hit_idx_q   <= hit_idx_d;
            score_l_q   <= score_l_d;
            score_r_q   <= score_r_d;
            game_over_q <= game_over_d;
            busy_q      <= busy_d;
            serve_cnt_q <= serve_cnt_d;
        end
    end

    assign ball_x    = ball_x_q;
    assign ball_y    = ball_y_q;
    assign hit_valid = hit_valid_q;
    assign hit_idx   = hit_idx_q;
    assign score_l   = score_l_q;
    assign score_r   = score_r_q;
    assign game_over = game_over_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_pong_collision_engine.sv
// Scoreboard bench: the driver queues hand-derived frame results, a monitor checks them when busy falls.
module tb_pong_collision_engine;

    localparam int NP = 2;
    localparam int CW = 13;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             new_frame = 1'b0;
    logic             pause = 1'b0;
    logic [NP*CW-1:0] pad_left = '0;
    logic [NP*CW-1:0] pad_right = '0;
    logic [NP*CW-1:0] pad_top = '0;
    logic [NP*CW-1:0] pad_bottom = '0;
    logic [CW-1:0]    ball_x, ball_y;
    logic             hit_valid;
    logic [2:0]       hit_idx;
    logic [3:0]       score_l, score_r;
    logic             game_over, busy;

    pong_collision_engine #(.NUM_PADDLES(NP), .COORD_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .new_frame  (new_frame),
        .pause      (pause),
        .pad_left   (pad_left),
        .pad_right  (pad_right),
        .pad_top    (pad_top),
        .pad_bottom (pad_bottom),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .hit_valid  (hit_valid),
        .hit_idx    (hit_idx),
        .score_l    (score_l),
        .score_r    (score_r),
        .game_over  (game_over),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit cx;
        bit cy;
        int x;
        int y;
        bit hit;
        int idx;
        int sl;
        int sr;
        bit go;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cur_sl = 0;
    int   cur_sr = 0;
    bit   busy_prev = 1'b0;

    function automatic exp_t mk(bit cx, bit cy, int x, int y, bit hit, int idx, int sl, int sr, bit go);
        exp_t e;
        e.cx = cx; e.cy = cy; e.x = x; e.y = y; e.hit = hit; e.idx = idx;
        e.sl = sl; e.sr = sr; e.go = go;
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a frame result is presented on the cycle busy drops.
    always @(negedge clk) begin
        if (busy_prev && !busy) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: ball=(%0d,%0d) with empty scoreboard", ball_x, ball_y);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.cx) chk("ball_x", int'(ball_x), mon_e.x);
                if (mon_e.cy) chk("ball_y", int'(ball_y), mon_e.y);
                chk("hit_valid", int'(hit_valid), int'(mon_e.hit));
                if (mon_e.hit) chk("hit_idx", int'(hit_idx), mon_e.idx);
                chk("score_l", int'(score_l), mon_e.sl);
                chk("score_r", int'(score_r), mon_e.sr);
                chk("game_over", int'(game_over), int'(mon_e.go));
            end
        end
        busy_prev = busy;
    end

    task automatic set_pad(input int i, input int l, input int r, input int t, input int b);
        pad_left  [i*CW +: CW] = CW'(l);
        pad_right [i*CW +: CW] = CW'(r);
        pad_top   [i*CW +: CW] = CW'(t);
        pad_bottom[i*CW +: CW] = CW'(b);
    endtask

    // mode 0 normal, 1 paused pulse, 2 extra pulse while busy, 3 pause raised mid-update
    task automatic frame(input bit resp, input exp_t e, input int mode);
        if (resp) sb.push_back(e);
        @(posedge clk); #1;
        new_frame = 1'b1;
        pause = (mode == 1);
        @(posedge clk); #1;
        new_frame = 1'b0;
        pause = (mode == 3);
        if (mode == 2) begin
            @(posedge clk); #1 new_frame = 1'b1;
            @(posedge clk); #1 new_frame = 1'b0;
        end
        repeat (6) @(posedge clk);
        #1 pause = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) frame(1'b1, mk(0, 0, 0, 0, 0, 0, cur_sl, cur_sr, 0), 0);
    endtask

    task automatic serve(input int n);
        for (int i = 0; i < n; i++) frame(1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 0);
    endtask

    task automatic check_reset_state();
        chk("rst_ball_x", int'(ball_x), 315);
        chk("rst_ball_y", int'(ball_y), 235);
        chk("rst_score_l", int'(score_l), 0);
        chk("rst_score_r", int'(score_r), 0);
        chk("rst_game_over", int'(game_over), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_hit_valid", int'(hit_valid), 0);
    endtask

    initial begin
        // Phase 1: both paddles share the right-hand box so the lower index wins.
        set_pad(0, 600, 619, 0, 479);
        set_pad(1, 600, 619, 0, 479);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check_reset_state();

        serve(60);
        chk("serve_hold_x", int'(ball_x), 315);
        chk("serve_hold_y", int'(ball_y), 235);

        sb.push_back(mk(1, 1, 319, 238, 0, 0, 0, 0, 0));
        @(posedge clk); #1 new_frame = 1'b1;
        @(posedge clk); #1 new_frame = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("latency_hold_x", int'(ball_x), 315);
        @(posedge clk);
        #1 chk("latency_x", int'(ball_x), 319);
        chk("latency_y", int'(ball_y), 238);
        repeat (4) @(posedge clk);

        run(66);
        frame(1'b1, mk(1, 1, 587, 439, 0, 0, 0, 0, 0), 0);
        frame(1'b1, mk(1, 1, 590, 442, 1, 0, 0, 0, 0), 0);
        set_pad(0, 4000, 4019, 4000, 4059);
        run(8);
        frame(1'b1, mk(1, 1, 554, 469, 0, 0, 0, 0, 0), 0);
        frame(1'b1, mk(1, 1, 550, 470, 0, 0, 0, 0, 0), 0);
        frame(1'b1, mk(1, 1, 546, 467, 0, 0, 0, 0, 0), 0);
        run(135);
        frame(1'b1, mk(1, 1, 2, 59, 0, 0, 0, 0, 0), 0);
        cur_sr = 1;
        frame(1'b1, mk(1, 1, 315, 235, 0, 0, 0, 1, 0), 0);

        // Phase 2: paused pulses never count toward the serve delay.
        serve(30);
        for (int i = 0; i < 3; i++) frame(1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 1);
        serve(30);
        chk("serve2_hold_x", int'(ball_x), 315);
        frame(1'b1, mk(1, 1, 319, 232, 0, 0, 0, 1, 0), 3);
        frame(1'b1, mk(1, 1, 323, 229, 0, 0, 0, 1, 0), 2);
        run(65);
        frame(1'b1, mk(1, 1, 587, 31, 0, 0, 0, 1, 0), 0);
        frame(1'b1, mk(1, 1, 590, 28, 1, 1, 0, 1, 0), 0);
        run(8);
        frame(1'b1, mk(1, 1, 554, 1, 0, 0, 0, 1, 0), 0);
        frame(1'b1, mk(1, 1, 550, 0, 0, 0, 0, 1, 0), 0);
        frame(1'b1, mk(1, 1, 546, 3, 0, 0, 0, 1, 0), 0);
        frame(1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 1);
        chk("idle_pause_x", int'(ball_x), 546);

        // Phase 3: left paddle only; the ball keeps leaving on the right.
        set_pad(1, 4000, 4019, 4000, 4059);
        set_pad(0, 20, 39, 0, 479);
        run(126);
        frame(1'b1, mk(1, 0, 40, 0, 1, 0, 0, 1, 0), 0);
        run(147);
        cur_sl = 1;
        frame(1'b1, mk(1, 1, 315, 235, 0, 0, 1, 1, 0), 0);
        for (int p = 2; p <= 9; p++) begin
            serve(60);
            run(68);
            frame(1'b1, mk(1, 0, 40, 0, 1, 0, cur_sl, 1, 0), 0);
            run(147);
            cur_sl = p;
            frame(1'b1, mk(1, 1, 315, 235, 0, 0, p, 1, p == 9), 0);
        end

        serve(5);
        chk("over_drained", sb.size(), 0);
        chk("over_ball_x", int'(ball_x), 315);
        chk("over_ball_y", int'(ball_y), 235);
        chk("over_score_l", int'(score_l), 9);
        chk("over_score_r", int'(score_r), 1);
        chk("over_game_over", int'(game_over), 1);
        chk("over_busy", int'(busy), 0);

        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        check_reset_state();

        repeat (10) @(posedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
